// File: rtl/chacha_round_sequencer.sv
// ChaCha block-function sequencer. Holds the 16-word state behind an
// Avalon-MM slave and walks an external quarter-round unit through the
// column/diagonal schedule, with an optional feed-forward add at the end.
module chacha_round_sequencer #(
    parameter int DEFAULT_DROUNDS = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        qr_req,
    output logic [31:0] qr_a,
    output logic [31:0] qr_b,
    output logic [31:0] qr_c,
    output logic [31:0] qr_d,
    input  logic        qr_ack,
    input  logic [31:0] qr_ra,
    input  logic [31:0] qr_rb,
    input  logic [31:0] qr_rc,
    input  logic [31:0] qr_rd
);

    // state  | meaning
    // IDLE   | waiting for CTRL.start, bus may write STATE/ROUNDS
    // ISSUE  | load operands for qr_idx, raise qr_req
    // WAIT   | hold request until qr_ack, then write results back
    // FINAL  | optional feed-forward add of the start snapshot
    // DONE   | clear busy, flag done
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FINAL,
        S_DONE
    } fsm_t;

    fsm_t        cur_st;
    fsm_t        nxt_st;

    logic [31:0] st_mem   [16];
    logic [31:0] init_mem [16];
    logic [7:0]  rounds;
    logic        busy;
    logic        done;
    logic        ff;
    logic [2:0]  qr_idx;
    logic [7:0]  dr_cnt;

    logic [3:0]  ia, ib, ic, id;
    logic        wr_en, rd_en, start, ack_ok, last_qr, last_dr;

    assign wr_en   = chipselect && write;
    assign rd_en   = chipselect && read && !write;
    assign start   = wr_en && (address == 5'd16) && writedata[0];
    assign ack_ok  = qr_ack && qr_req;
    assign last_qr = (qr_idx == 3'd7);
    assign last_dr = (({1'b0, dr_cnt} + 9'd1) >= {1'b0, rounds});

    // Column rounds use indices 0-3, diagonal rounds 4-7.
    always_comb begin
        {ia, ib, ic, id} = {4'd0, 4'd4, 4'd8, 4'd12};
        case (qr_idx)
            3'd0: {ia, ib, ic, id} = {4'd0, 4'd4, 4'd8,  4'd12};
            3'd1: {ia, ib, ic, id} = {4'd1, 4'd5, 4'd9,  4'd13};
            3'd2: {ia, ib, ic, id} = {4'd2, 4'd6, 4'd10, 4'd14};
            3'd3: {ia, ib, ic, id} = {4'd3, 4'd7, 4'd11, 4'd15};
            3'd4: {ia, ib, ic, id} = {4'd0, 4'd5, 4'd10, 4'd15};
            3'd5: {ia, ib, ic, id} = {4'd1, 4'd6, 4'd11, 4'd12};
            3'd6: {ia, ib, ic, id} = {4'd2, 4'd7, 4'd8,  4'd13};
            3'd7: {ia, ib, ic, id} = {4'd3, 4'd4, 4'd9,  4'd14};
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur_st <= S_IDLE;
        else          cur_st <= nxt_st;
    end

    // Next-state selection.
    always_comb begin
        nxt_st = cur_st;
        case (cur_st)
            S_IDLE:  if (start) nxt_st = (rounds == 8'd0) ? S_FINAL : S_ISSUE;
            S_ISSUE: nxt_st = S_WAIT;
            S_WAIT: begin
                if (ack_ok) begin
                    if (last_qr && last_dr) nxt_st = S_FINAL;
                    else                    nxt_st = S_ISSUE;
                end
            end
            S_FINAL: nxt_st = S_DONE;
            S_DONE:  nxt_st = S_IDLE;
            default: nxt_st = S_IDLE;
        endcase
    end

    // Bus register file plus the datapath actions of each FSM state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            qr_req   <= 1'b0;
            qr_a     <= '0;
            qr_b     <= '0;
            qr_c     <= '0;
            qr_d     <= '0;
            rounds   <= 8'(DEFAULT_DROUNDS);
            busy     <= 1'b0;
            done     <= 1'b0;
            ff       <= 1'b0;
            qr_idx   <= '0;
            dr_cnt   <= '0;
            for (int n = 0; n < 16; n++) begin
                st_mem[n]   <= '0;
                init_mem[n] <= '0;
            end
        end else begin
            readdata <= '0;
            if (rd_en) begin
                if (!address[4]) begin
                    readdata <= st_mem[address[3:0]];
                end else begin
                    case (address)
                        5'd17:   readdata <= {30'b0, done, busy};
                        5'd18:   readdata <= {24'b0, rounds};
                        default: readdata <= '0;
                    endcase
                end
                if (address == 5'd17) done <= 1'b0;
            end

            if (wr_en && !busy) begin
                if (!address[4])        st_mem[address[3:0]] <= writedata;
                if (address == 5'd18)   rounds <= writedata[7:0];
            end

            case (cur_st)
                S_IDLE: begin
                    if (start) begin
                        for (int n = 0; n < 16; n++) init_mem[n] <= st_mem[n];
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        ff     <= writedata[1];
                        qr_idx <= '0;
                        dr_cnt <= '0;
                    end
                end
                S_ISSUE: begin
                    qr_a   <= st_mem[ia];
                    qr_b   <= st_mem[ib];
                    qr_c   <= st_mem[ic];
                    qr_d   <= st_mem[id];
                    qr_req <= 1'b1;
                end
                S_WAIT: begin
                    if (ack_ok) begin
                        st_mem[ia] <= qr_ra;
                        st_mem[ib] <= qr_rb;
                        st_mem[ic] <= qr_rc;
                        st_mem[id] <= qr_rd;
                        qr_req     <= 1'b0;
                        if (!last_qr) begin
                            qr_idx <= qr_idx + 3'd1;
                        end else begin
                            qr_idx <= '0;
                            dr_cnt <= dr_cnt + 8'd1;
                        end
                    end
                end
                S_FINAL: begin
                    if (ff) begin
                        for (int n = 0; n < 16; n++) st_mem[n] <= st_mem[n] + init_mem[n];
                    end
                end
                S_DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
